// File: rtl/mips_instr_encoder.sv
// MIPS R/I/J word encoder writing legal words into a DEPTH-entry program memory with a registered read port.
// Accept->ENC->WR takes 3 cycles; in_ready is high only in IDLE, and FULL stalls requests until clr or reset.
module mips_instr_encoder #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_fmt,
  input  logic [5:0]    in_op,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [5:0]    in_funct,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  input  logic          clr,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  output logic          wr_done,
  output logic [31:0]   word,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          err,
  output logic [2:0]    err_cnt
);

  typedef enum logic [1:0] {IDLE, ENC, WR, FULL} state_t;

  state_t        state, state_d;
  logic          accept;
  logic [1:0]    f_fmt;
  logic [5:0]    f_op, f_funct;
  logic [4:0]    f_rs, f_rt, f_rd, f_shamt;
  logic [15:0]   f_imm;
  logic [25:0]   f_target;
  logic [31:0]   word_q, enc_word;
  logic          legal_q, enc_legal;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    accept   = 1'b0;
    wr_done  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ENC;
        end
      end
      ENC: state_d = WR;
      WR: begin
        wr_done = legal_q;
        state_d = (legal_q && count == CW'(DEPTH - 1)) ? FULL : IDLE;
      end
      FULL: state_d = FULL;
      default: state_d = IDLE;
    endcase
    // clr drops any in-flight request and wins over a same-cycle accept
    if (clr) begin
      state_d = IDLE;
      accept  = 1'b0;
      wr_done = 1'b0;
    end
  end

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b0;
    case (f_fmt)
      2'd0: begin
        enc_word  = {6'h00, f_rs, f_rt, f_rd, f_shamt, f_funct};
        enc_legal = (f_op == 6'd0);
      end
      2'd1: begin
        enc_word  = {f_op, f_rs, f_rt, f_imm};
        enc_legal = (f_op != 6'd0) && (f_op != 6'd2) && (f_op != 6'd3);
      end
      2'd2: begin
        enc_word  = {f_op, f_target};
        enc_legal = (f_op == 6'd2) || (f_op == 6'd3);
      end
      default: begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_fmt    <= '0;
      f_op     <= '0;
      f_rs     <= '0;
      f_rt     <= '0;
      f_rd     <= '0;
      f_shamt  <= '0;
      f_funct  <= '0;
      f_imm    <= '0;
      f_target <= '0;
      word_q   <= '0;
      legal_q  <= 1'b0;
    end else begin
      if (accept) begin
        f_fmt    <= in_fmt;
        f_op     <= in_op;
        f_rs     <= in_rs;
        f_rt     <= in_rt;
        f_rd     <= in_rd;
        f_shamt  <= in_shamt;
        f_funct  <= in_funct;
        f_imm    <= in_imm;
        f_target <= in_target;
      end
      if (state == ENC && !clr) begin
        word_q  <= enc_word;
        legal_q <= enc_legal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      count   <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (clr) begin
      wr_ptr  <= '0;
      count   <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (state == WR) begin
      if (legal_q) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + CW'(1);
      end else begin
        err <= 1'b1;
        if (err_cnt != 3'd7) err_cnt <= err_cnt + 3'd1;
      end
    end
  end

  // read samples the pre-write contents, giving read-before-write on a shared address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_done) mem[wr_ptr] <= word_q;
      rd_data <= mem[rd_addr];
    end
  end

  assign word = word_q;
  assign full = (count == CW'(DEPTH));

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: directed and randomized requests checked against an arithmetic reference model.
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [5:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        clr;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wr_done;
  logic [31:0] word;
  logic [3:0]  count;
  logic        full;
  logic        err;
  logic [2:0]  err_cnt;

  mips_instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .clr(clr), .rd_addr(rd_addr), .rd_data(rd_data), .wr_done(wr_done), .word(word),
    .count(count), .full(full), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] m_mem [8];
  int          m_ptr, m_cnt, m_errcnt;
  int          m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int fmt, op, rs, rt, rd, sh, fn, imm, tgt);
    longint w;
    case (fmt)
      0:       w = rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn;
      1:       w = longint'(op) * 67108864 + rs * 2097152 + rt * 65536 + imm;
      2:       w = longint'(op) * 67108864 + tgt;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  function automatic int ref_legal(input int fmt, op);
    case (fmt)
      0:       return (op == 0) ? 1 : 0;
      1:       return (op == 0 || op == 2 || op == 3) ? 0 : 1;
      2:       return (op == 2 || op == 3) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic scramble();
    in_fmt = 2'($urandom); in_op = 6'($urandom); in_rs = 5'($urandom); in_rt = 5'($urandom);
    in_rd = 5'($urandom); in_shamt = 5'($urandom); in_funct = 6'($urandom);
    in_imm = 16'($urandom); in_target = 26'($urandom);
  endtask

  task automatic drive(input int fmt, op, rs, rt, rd, sh, fn, imm, tgt);
    in_fmt = 2'(fmt); in_op = 6'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_shamt = 5'(sh); in_funct = 6'(fn); in_imm = 16'(imm); in_target = 26'(tgt);
  endtask

  // full accept -> ENC -> WR handshake, checking outputs against the model in each phase
  task automatic do_req(input int fmt, op, rs, rt, rd, sh, fn, imm, tgt);
    logic [31:0] w;
    int lg;
    w  = ref_word(fmt, op, rs, rt, rd, sh, fn, imm, tgt);
    lg = ref_legal(fmt, op);
    chk("ready_idle", in_ready, 1);
    in_valid = 1'b1;
    drive(fmt, op, rs, rt, rd, sh, fn, imm, tgt);
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
    chk("ready_enc", in_ready, 0);
    chk("done_enc", wr_done, 0);
    @(negedge clk);
    chk("wr_done", wr_done, lg);
    chk("word", word, w);
    @(negedge clk);
    if (lg != 0) begin
      m_mem[m_ptr] = w;
      m_ptr = (m_ptr + 1) % 8;
      m_cnt++;
    end else begin
      m_err = 1;
      if (m_errcnt < 7) m_errcnt++;
    end
    chk("count", count, m_cnt);
    chk("err", err, m_err);
    chk("err_cnt", err_cnt, m_errcnt);
    chk("full", full, (m_cnt == 8) ? 1 : 0);
    chk("ready_after", in_ready, (m_cnt == 8) ? 0 : 1);
  endtask

  task automatic rand_legal();
    int fmt, op;
    fmt = $urandom_range(0, 2);
    case (fmt)
      0:       op = 0;
      1:       op = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(4, 63);
      default: op = $urandom_range(2, 3);
    endcase
    do_req(fmt, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
           $urandom_range(0, 67108863));
  endtask

  task automatic rand_any();
    int fmt, op;
    fmt = $urandom_range(0, 3);
    op  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 3);
    do_req(fmt, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
           $urandom_range(0, 67108863));
  endtask

  task automatic rd_chk(input int a, input logic [31:0] exp, input string tag);
    rd_addr = 3'(a);
    @(negedge clk);
    chk(tag, rd_data, exp);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_ptr = 0; m_cnt = 0; m_err = 0; m_errcnt = 0;
    chk("clr_count", count, 0);
    chk("clr_err", err, 0);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_full", full, 0);
    chk("clr_ready", in_ready, 1);
  endtask

  task automatic reset_chk();
    chk("rst_ready", in_ready, 1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_word", word, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; rd_addr = 3'd0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) m_mem[i] = 32'h0;
    m_ptr = 0; m_cnt = 0; m_err = 0; m_errcnt = 0;
    repeat (2) @(negedge clk);
    reset_chk();
    rst_n = 1'b1;
    @(negedge clk);

    // directed legal words
    do_req(0, 0, 5, 4, 6, 0, 'h20, 0, 0);
    do_req(1, 8, 0, 4, 0, 0, 0, 'h3456, 0);
    do_req(2, 2, 0, 0, 0, 0, 0, 0, 'h123456);
    do_req(0, 0, 0, 3, 3, 1, 2, 0, 0);
    rd_chk(0, 32'h00A43020, "rd_add");
    rd_chk(1, 32'h20043456, "rd_addi");
    rd_chk(2, 32'h08123456, "rd_j");
    rd_chk(3, 32'h00031842, "rd_srl");

    // illegal requests, then saturation of the error counter
    do_req(0, 8, 1, 2, 3, 0, 'h20, 0, 0);
    do_req(2, 8, 0, 0, 0, 0, 0, 0, 'h1234);
    do_req(3, 0, 1, 1, 1, 1, 1, 1, 1);
    do_req(1, 0, 1, 2, 0, 0, 0, 'h55, 0);
    chk("err_cnt_4", err_cnt, 4);
    chk("count_after_illegal", count, 4);
    for (int i = 0; i < 8; i++) do_req(3, $urandom_range(0, 63), 0, 0, 0, 0, 0, 0, 0);
    chk("err_cnt_sat", err_cnt, 7);

    // fill, then a request in FULL must be ignored
    for (int i = 0; i < 4; i++) rand_legal();
    chk("full_set", full, 1);
    in_valid = 1'b1;
    drive(0, 0, 1, 2, 3, 0, 'h20, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_no_done", wr_done, 0);
      chk("full_no_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("full_count_held", count, 8);
    chk("full_err_held", err_cnt, 7);
    for (int i = 0; i < 8; i++) rd_chk(i, m_mem[i], "rd_full");

    // clr, then overwrite addr 0 while reading it: old value first, new one a cycle later
    do_clr();
    rd_addr = 3'd0;
    begin
      logic [31:0] old0;
      old0 = m_mem[0];
      do_req(2, 3, 0, 0, 0, 0, 0, 0, $urandom_range(0, 67108863));
      chk("rbw_old", rd_data, old0);
      @(negedge clk);
      chk("rbw_new", rd_data, m_mem[0]);
    end
    for (int i = 1; i < 8; i++) rd_chk(i, m_mem[i], "rd_kept");

    // random mix with readbacks
    for (int n = 0; n < 20; n++) begin
      if (m_cnt == 8) do_clr();
      rand_any();
      if (n % 4 == 3) begin
        int a;
        a = $urandom_range(0, 7);
        rd_chk(a, m_mem[a], "rd_rand");
      end
    end

    // clr during ENC drops the request
    if (m_cnt == 8) do_clr();
    rand_legal();
    chk("ready_pre_clr", in_ready, 1);
    in_valid = 1'b1;
    drive(0, 0, 7, 7, 7, 0, 'h20, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_ptr = 0; m_cnt = 0; m_err = 0; m_errcnt = 0;
    chk("clr_enc_done", wr_done, 0);
    chk("clr_enc_ready", in_ready, 1);
    chk("clr_enc_count", count, 0);
    @(negedge clk);
    chk("clr_enc_done2", wr_done, 0);
    chk("clr_enc_count2", count, 0);

    // reset during ENC: no write, everything back to reset values
    do_req(1, 9, 1, 2, 0, 0, 0, 'h77, 0);
    in_valid = 1'b1;
    drive(0, 0, 1, 1, 1, 0, 'h21, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_chk();
    for (int i = 0; i < 8; i++) m_mem[i] = 32'h0;
    m_ptr = 0; m_cnt = 0; m_err = 0; m_errcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", wr_done, 0);
    chk("post_rst_count", count, 0);
    for (int i = 0; i < 8; i++) rd_chk(i, m_mem[i], "rd_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
